// File: rtl/mem_to_axi_lite.sv
// rtl/mem_to_axi_lite.sv - bridges a single-outstanding memory request port onto an AXI-Lite master
module mem_to_axi_lite #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    mem_req_i,
    output logic                    mem_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic                    mem_we_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] mem_strb_i,
    output logic                    mem_rvalid_o,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,
    output logic                    mem_err_o,

    output logic [ADDR_WIDTH-1:0]   aw_addr_o,
    output logic [2:0]              aw_prot_o,
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    output logic [DATA_WIDTH-1:0]   w_data_o,
    output logic [DATA_WIDTH/8-1:0] w_strb_o,
    output logic                    w_valid_o,
    input  logic                    w_ready_i,
    input  logic [1:0]              b_resp_i,
    input  logic                    b_valid_i,
    output logic                    b_ready_o,
    output logic [ADDR_WIDTH-1:0]   ar_addr_o,
    output logic [2:0]              ar_prot_o,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    input  logic [DATA_WIDTH-1:0]   r_data_i,
    input  logic [1:0]              r_resp_i,
    input  logic                    r_valid_i,
    output logic                    r_ready_o
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] strb_q;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  aw_done;
    logic                  w_done;
    logic                  unused_resp_lsb;

    // Only resp[1] distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    assign unused_resp_lsb = b_resp_i[0] ^ r_resp_i[0];

    assign mem_gnt_o = (state == IDLE) && mem_req_i && !rst;

    assign aw_addr_o = addr_q;
    assign ar_addr_o = addr_q;
    assign w_data_o  = wdata_q;
    assign w_strb_o  = strb_q;
    assign aw_prot_o = 3'b000;
    assign ar_prot_o = 3'b000;

    // A channel counts as done once its valid has dropped or is handshaking now.
    assign aw_hs   = aw_valid_o && aw_ready_i;
    assign w_hs    = w_valid_o && w_ready_i;
    assign aw_done = !aw_valid_o || aw_hs;
    assign w_done  = !w_valid_o || w_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
            aw_valid_o   <= 1'b0;
            w_valid_o    <= 1'b0;
            b_ready_o    <= 1'b0;
            ar_valid_o   <= 1'b0;
            r_ready_o    <= 1'b0;
            mem_rvalid_o <= 1'b0;
            mem_rdata_o  <= '0;
            mem_err_o    <= 1'b0;
        end else begin
            mem_rvalid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req_i) begin
                        addr_q  <= mem_addr_i;
                        wdata_q <= mem_wdata_i;
                        strb_q  <= mem_strb_i;
                        if (mem_we_i) begin
                            aw_valid_o <= 1'b1;
                            w_valid_o  <= 1'b1;
                            state      <= WR_ADDR_DATA;
                        end else begin
                            ar_valid_o <= 1'b1;
                            state      <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (aw_hs) begin
                        aw_valid_o <= 1'b0;
                    end
                    if (w_hs) begin
                        w_valid_o <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        b_ready_o <= 1'b1;
                        state     <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_valid_i) begin
                        b_ready_o    <= 1'b0;
                        mem_rvalid_o <= 1'b1;
                        mem_rdata_o  <= '0;
                        mem_err_o    <= b_resp_i[1];
                        state        <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (ar_ready_i) begin
                        ar_valid_o <= 1'b0;
                        r_ready_o  <= 1'b1;
                        state      <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_valid_i) begin
                        r_ready_o    <= 1'b0;
                        mem_rvalid_o <= 1'b1;
                        mem_rdata_o  <= r_data_i;
                        mem_err_o    <= r_resp_i[1];
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_to_axi_lite.sv
// tb/tb_mem_to_axi_lite.sv - self-checking bench for mem_to_axi_lite with a delaying AXI-Lite slave memory
module tb_mem_to_axi_lite;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_i, mem_gnt_o, mem_we_i, mem_rvalid_o, mem_err_o;
    logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
    logic [3:0]  mem_strb_i;
    logic [31:0] aw_addr_o, w_data_o, ar_addr_o, r_data_i;
    logic [2:0]  aw_prot_o, ar_prot_o;
    logic [3:0]  w_strb_o;
    logic        aw_valid_o, aw_ready_i, w_valid_o, w_ready_i, b_valid_i, b_ready_o;
    logic        ar_valid_o, ar_ready_i, r_valid_i, r_ready_o;
    logic [1:0]  b_resp_i, r_resp_i;

    always #5 clk = ~clk;

    mem_to_axi_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o), .mem_addr_i(mem_addr_i), .mem_we_i(mem_we_i),
        .mem_wdata_i(mem_wdata_i), .mem_strb_i(mem_strb_i), .mem_rvalid_o(mem_rvalid_o),
        .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
        .aw_addr_o(aw_addr_o), .aw_prot_o(aw_prot_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .ar_addr_o(ar_addr_o), .ar_prot_o(ar_prot_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
    );

    typedef struct {
        int         aw_dly, w_dly, ar_dly, b_dly, r_dly;
        logic [1:0] resp;
    } cfg_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr, wdata;
        logic [3:0]  strb;
        logic        pre;
        logic [31:0] preload;
        int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    cfg_t        cfg_q[$];
    exp_t        sb_q[$];
    logic [31:0] slave_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic cfg_t mk_cfg(input int aw, input int w, input int ar, input int b, input int r,
                                    input logic [1:0] resp);
        cfg_t c;
        c.aw_dly = aw; c.w_dly = w; c.ar_dly = ar; c.b_dly = b; c.r_dly = r; c.resp = resp;
        return c;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] rdata, input logic err);
        exp_t e;
        e.rdata = rdata; e.err = err;
        return e;
    endfunction

    // AXI-Lite slave memory: readies/responses delayed per transaction config, driven at negedge.
    cfg_t        cur;
    logic        busy, got_aw, got_w, got_ar, wrote;
    logic        p_aw, p_w, p_b, p_ar, p_r;
    logic        hold_aw, hold_w, hold_ar;
    logic [31:0] hold_aw_addr, hold_w_data, hold_ar_addr;
    logic [3:0]  hold_w_strb;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr, m;
    logic [3:0]  cap_strb;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;

    initial begin
        aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0; b_valid_i = 0; r_valid_i = 0;
        b_resp_i = 0; r_resp_i = 0; r_data_i = 0;
        busy = 0; got_aw = 0; got_w = 0; got_ar = 0; wrote = 0;
        p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0; hold_aw = 0; hold_w = 0; hold_ar = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0; b_valid_i = 0; r_valid_i = 0;
                busy = 0; got_aw = 0; got_w = 0; got_ar = 0; wrote = 0;
                p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0; hold_aw = 0; hold_w = 0; hold_ar = 0;
                cfg_q.delete();
            end else begin
                if (hold_aw) check("aw_hold", {aw_valid_o, aw_addr_o}, {1'b1, hold_aw_addr});
                if (hold_w)  check("w_hold", {w_valid_o, w_strb_o, w_data_o}, {1'b1, hold_w_strb, hold_w_data});
                if (hold_ar) check("ar_hold", {ar_valid_o, ar_addr_o}, {1'b1, hold_ar_addr});
                if (p_aw) got_aw = 1;
                if (p_w)  got_w = 1;
                if (p_ar) got_ar = 1;
                if (p_b) begin b_valid_i = 0; busy = 0; end
                if (p_r) begin r_valid_i = 0; busy = 0; end
                if (!busy && (aw_valid_o || ar_valid_o)) begin
                    if (cfg_q.size() == 0) begin
                        check("slave_cfg_available", 64'(cfg_q.size()), 64'd1);
                        cur = mk_cfg(0, 0, 0, 0, 0, 2'b00);
                    end else begin
                        cur = cfg_q.pop_front();
                    end
                    busy = 1; got_aw = 0; got_w = 0; got_ar = 0; wrote = 0;
                    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                end
                aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
                if (busy) begin
                    if (aw_valid_o && !got_aw) begin
                        if (aw_cnt >= cur.aw_dly) begin aw_ready_i = 1; cap_awaddr = aw_addr_o; end
                        else aw_cnt++;
                    end
                    if (w_valid_o && !got_w) begin
                        if (w_cnt >= cur.w_dly) begin w_ready_i = 1; cap_wdata = w_data_o; cap_strb = w_strb_o; end
                        else w_cnt++;
                    end
                    if (ar_valid_o && !got_ar) begin
                        if (ar_cnt >= cur.ar_dly) begin ar_ready_i = 1; cap_araddr = ar_addr_o; end
                        else ar_cnt++;
                    end
                    if (got_aw && got_w && !wrote) begin
                        m = slave_mem.exists(cap_awaddr) ? slave_mem[cap_awaddr] : 32'h0;
                        for (int b = 0; b < 4; b++) if (cap_strb[b]) m[b*8 +: 8] = cap_wdata[b*8 +: 8];
                        slave_mem[cap_awaddr] = m;
                        wrote = 1;
                    end
                    if (wrote && !b_valid_i) begin
                        if (b_cnt >= cur.b_dly) begin b_valid_i = 1; b_resp_i = cur.resp; end
                        else b_cnt++;
                    end
                    if (got_ar && !r_valid_i) begin
                        if (r_cnt >= cur.r_dly) begin
                            r_valid_i = 1; r_resp_i = cur.resp;
                            r_data_i = slave_mem.exists(cap_araddr) ? slave_mem[cap_araddr] : 32'h0;
                        end else r_cnt++;
                    end
                end
                p_aw = aw_valid_o && aw_ready_i;
                p_w  = w_valid_o && w_ready_i;
                p_ar = ar_valid_o && ar_ready_i;
                p_b  = b_valid_i && b_ready_o;
                p_r  = r_valid_i && r_ready_o;
                hold_aw = aw_valid_o && !aw_ready_i; hold_aw_addr = aw_addr_o;
                hold_w  = w_valid_o && !w_ready_i;   hold_w_data = w_data_o; hold_w_strb = w_strb_o;
                hold_ar = ar_valid_o && !ar_ready_i; hold_ar_addr = ar_addr_o;
            end
        end
    end

    // Scoreboard: every response pulse pops the expectation pushed at grant time.
    logic prev_rvalid = 1'b0;
    exp_t got_e;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && mem_rvalid_o) begin
                check("rvalid_single_pulse", 64'(prev_rvalid), 64'd0);
                check("rvalid_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    got_e = sb_q.pop_front();
                    check("rdata", 64'(mem_rdata_o), 64'(got_e.rdata));
                    check("err", 64'(mem_err_o), 64'(got_e.err));
                end
            end
            prev_rvalid = mem_rvalid_o && !rst;
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input cfg_t c, input exp_t e);
        int t;
        t = 0;
        mem_req_i = 1; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wdata; mem_strb_i = strb;
        #1;
        while (!mem_gnt_o && t < 200) begin
            @(negedge clk); #1; t++;
        end
        if (!mem_gnt_o) check("grant_timeout", 64'(mem_gnt_o), 64'd1);
        else begin
            cfg_q.push_back(c);
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 300) begin
            @(negedge clk); t++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
    endtask

    vec_t        vecs[8];
    vec_t        v;
    cfg_t        c;
    exp_t        e;
    logic        we, got;
    logic [31:0] addr, wdata, rd;
    logic [3:0]  strb;
    logic [1:0]  resp;
    int          n_ar, n_rv;

    initial begin
        vecs[0] = '{1'b1, 32'h4000_0000, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,        0, 0, 0, 0, 0, 2'b00, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 32'h4000_0010, 32'h0,        4'h0, 1'b1, 32'h1234_5678, 0, 0, 3, 0, 0, 2'b00, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 32'h4000_0020, 32'h0,        4'h0, 1'b1, 32'hCAFE_F00D, 0, 0, 0, 0, 2, 2'b10, 32'hCAFE_F00D, 1'b1};
        vecs[3] = '{1'b1, 32'h4000_0024, 32'h5566_7788, 4'hF, 1'b0, 32'h0,        0, 0, 0, 2, 0, 2'b11, 32'h0,        1'b1};
        vecs[4] = '{1'b1, 32'h4000_0024, 32'h1122_3344, 4'h3, 1'b0, 32'h0,        1, 3, 0, 0, 0, 2'b01, 32'h0,        1'b0};
        vecs[5] = '{1'b0, 32'h4000_0024, 32'h0,        4'h0, 1'b0, 32'h0,        0, 0, 1, 0, 1, 2'b00, 32'h5566_3344, 1'b0};
        vecs[6] = '{1'b0, 32'h4000_0003, 32'h0,        4'h0, 1'b1, 32'h0BAD_C0DE, 0, 0, 0, 0, 0, 2'b11, 32'h0BAD_C0DE, 1'b1};
        vecs[7] = '{1'b0, 32'h4000_0000, 32'h0,        4'h0, 1'b0, 32'h0,        0, 2, 2, 0, 0, 2'b00, 32'hDEAD_BEEF, 1'b0};

        rst = 1; mem_req_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_wdata_i = 0; mem_strb_i = 0;
        repeat (3) @(negedge clk);
        mem_req_i = 1;
        #1;
        check("rst_gnt", 64'(mem_gnt_o), 64'd0);
        check("rst_valids", {aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o, mem_rvalid_o, mem_err_o}, 64'd0);
        check("rst_payload", {mem_rdata_o, aw_addr_o}, 64'd0);
        check("rst_prot", {aw_prot_o, ar_prot_o}, 64'd0);
        @(negedge clk);
        rst = 0; mem_req_i = 0;
        @(negedge clk);

        // Zero-wait write: gnt c0, aw/w c1, b_ready c2, rvalid c3.
        issue(1'b1, 32'h4000_0000, 32'hDEAD_BEEF, 4'hF, mk_cfg(0, 0, 0, 0, 0, 2'b00), mk_exp(32'h0, 1'b0));
        check("c0_idle_valids", {aw_valid_o, w_valid_o}, 64'd0);
        @(negedge clk); mem_req_i = 0; #1;
        check("c1_aw_w_b", {aw_valid_o, w_valid_o, b_ready_o, mem_rvalid_o}, 64'b1100);
        check("c1_payload", {aw_addr_o, w_data_o}, {32'h4000_0000, 32'hDEAD_BEEF});
        @(negedge clk); #1;
        check("c2_aw_w_b", {aw_valid_o, w_valid_o, b_ready_o, mem_rvalid_o}, 64'b0010);
        @(negedge clk); #1;
        check("c3_rvalid", {b_ready_o, mem_rvalid_o}, 64'b01);
        wait_idle();

        // Read with ar_ready delayed 3; request held high to probe grant outside IDLE and turnaround.
        slave_mem[32'h4000_0010] = 32'h1234_5678;
        issue(1'b0, 32'h4000_0010, 32'h0, 4'h0, mk_cfg(0, 0, 3, 0, 0, 2'b00), mk_exp(32'h1234_5678, 1'b0));
        n_ar = 0; got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk); #1;
            if (mem_rvalid_o) got = 1;
            else begin
                check("gnt_busy", 64'(mem_gnt_o), 64'd0);
                if (ar_valid_o) begin
                    n_ar++;
                    check("ar_addr", 64'(ar_addr_o), 64'h4000_0010);
                end
            end
        end
        check("rd_done", 64'(got), 64'd1);
        check("ar_cycles", 64'(n_ar), 64'd4);
        check("gnt_turnaround", 64'(mem_gnt_o), 64'd1);
        if (mem_gnt_o) begin
            cfg_q.push_back(mk_cfg(0, 0, 0, 0, 0, 2'b00));
            sb_q.push_back(mk_exp(32'h1234_5678, 1'b0));
        end
        @(negedge clk); mem_req_i = 0;
        wait_idle();

        // W completes two cycles ahead of AW.
        issue(1'b1, 32'h4000_0030, 32'hA5A5_5A5A, 4'hF, mk_cfg(2, 0, 0, 0, 0, 2'b00), mk_exp(32'h0, 1'b0));
        @(negedge clk); mem_req_i = 0; #1;
        check("w_early_c1", {aw_valid_o, w_valid_o, b_ready_o}, 64'b110);
        @(negedge clk); #1;
        check("w_early_c2", {aw_valid_o, w_valid_o, b_ready_o}, 64'b100);
        @(negedge clk); #1;
        check("w_early_c3", {aw_valid_o, w_valid_o, b_ready_o}, 64'b100);
        @(negedge clk); #1;
        check("w_early_c4", {aw_valid_o, w_valid_o, b_ready_o}, 64'b001);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            if (v.pre) slave_mem[v.addr] = v.preload;
            issue(v.we, v.addr, v.wdata, v.strb, mk_cfg(v.aw_dly, v.w_dly, v.ar_dly, v.b_dly, v.r_dly, v.resp),
                  mk_exp(v.exp_rdata, v.exp_err));
            @(negedge clk); mem_req_i = 0;
            wait_idle();
        end

        // Reset while waiting in WR_RESP, with a new request pending.
        issue(1'b1, 32'h4000_0040, 32'h7777_7777, 4'hF, mk_cfg(0, 0, 0, 5, 0, 2'b00), mk_exp(32'h0, 1'b0));
        @(negedge clk); mem_req_i = 0;
        @(negedge clk); #1;
        check("wr_resp_before_rst", 64'(b_ready_o), 64'd1);
        rst = 1; mem_req_i = 1; mem_we_i = 0;
        sb_q.delete();
        @(negedge clk); #1;
        check("rst_mid_gnt", 64'(mem_gnt_o), 64'd0);
        check("rst_mid_ctrl", {aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o, mem_rvalid_o, mem_err_o}, 64'd0);
        check("rst_mid_payload", {aw_addr_o, w_data_o}, 64'd0);
        check("rst_mid_rdata_strb", {mem_rdata_o, w_strb_o}, 64'd0);
        @(negedge clk);
        rst = 0; mem_req_i = 0;
        n_rv = 0;
        repeat (8) begin
            @(negedge clk); #1;
            if (mem_rvalid_o) n_rv++;
        end
        check("no_rvalid_after_rst", 64'(n_rv), 64'd0);

        // Random-ready stress against a reference memory, with back-to-back requests.
        for (int n = 0; n < 1000; n++) begin
            we = 1'($urandom_range(0, 1));
            addr = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            wdata = $urandom;
            strb = 4'($urandom_range(0, 15));
            resp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            c = mk_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3), resp);
            rd = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
            if (we) begin
                for (int b = 0; b < 4; b++) if (strb[b]) rd[b*8 +: 8] = wdata[b*8 +: 8];
                ref_mem[addr] = rd;
                e = mk_exp(32'h0, resp[1]);
            end else begin
                e = mk_exp(rd, resp[1]);
            end
            issue(we, addr, wdata, strb, c, e);
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                mem_req_i = 0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        mem_req_i = 0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks %0d failures", n_checks, n_fail);
        $fatal(1);
    end
endmodule
